// File: rtl/register_dump.sv
// ----------------------------------------------------------------------------
// register_dump
//
// Sequential debug reader for the MiniMIPS 8x32 register file. A start pulse
// walks the contiguous address range first_reg..last_reg through one read port.
// The range wraps modulo 8 when last_reg < first_reg. Each captured word is
// streamed out on a valid/ready handshake, and the emitted words are folded
// into an XOR checksum.
//
// Ports
//   clock      in   rising-edge clock, shared with the register file
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle dump request, sampled only while idle
//   first_reg  in   first address of the range, latched on accepted start
//   last_reg   in   last address of the range (inclusive), latched on start
//   read_reg   out  address driven to the register file read port
//   read_data  in   combinational read data for read_reg
//   out_valid  out  out_data/out_index hold a word
//   out_ready  in   downstream accepts the word when high with out_valid
//   out_data   out  captured register value
//   out_index  out  address the word was read from
//   busy       out  high from start acceptance through the done cycle
//   done       out  one-cycle pulse after the last word's handshake
//   checksum   out  XOR of all words emitted in the current or last dump
// ----------------------------------------------------------------------------
module register_dump #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   output logic [ADDR_W-1:0] read_reg,
   input  logic [DATA_W-1:0] read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // The address is ADDR_W bits wide, so a plain increment already wraps
   // modulo the register count.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      next_addr = a + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

   logic [1:0]        state_r,     state_nx_s;
   logic [ADDR_W-1:0] addr_r,      addr_nx_s;
   logic [ADDR_W-1:0] last_r,      last_nx_s;
   logic [DATA_W-1:0] data_r,      data_nx_s;
   logic [ADDR_W-1:0] index_r,     index_nx_s;
   logic [DATA_W-1:0] checksum_r,  checksum_nx_s;
   logic              valid_r,     valid_nx_s;
   logic              busy_r,      busy_nx_s;
   logic              done_r,      done_nx_s;
   logic              handshake_s;

   // valid_r is high exactly in SEND, so it doubles as the SEND indicator.
   assign handshake_s = valid_r & out_ready;

   // Next-state and next-output computation for the dump sequencer.
   always_comb begin
      state_nx_s    = state_r;
      addr_nx_s     = addr_r;
      last_nx_s     = last_r;
      data_nx_s     = data_r;
      index_nx_s    = index_r;
      checksum_nx_s = checksum_r;
      valid_nx_s    = valid_r;
      busy_nx_s     = busy_r;
      done_nx_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               addr_nx_s     = first_reg;
               last_nx_s     = last_reg;
               checksum_nx_s = {DATA_W{1'b0}};
               busy_nx_s     = 1'b1;
               state_nx_s    = ST_FETCH;
            end else begin
               state_nx_s    = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // read_reg already equals addr_r, so read_data is this word.
            data_nx_s  = read_data;
            index_nx_s = addr_r;
            valid_nx_s = 1'b1;
            state_nx_s = ST_SEND;
         end
         ST_SEND: begin
            if (handshake_s) begin
               checksum_nx_s = checksum_r ^ data_r;
               valid_nx_s    = 1'b0;
               if (addr_r == last_r) begin
                  done_nx_s  = 1'b1;
                  state_nx_s = ST_DONE;
               end else begin
                  addr_nx_s  = next_addr(addr_r);
                  state_nx_s = ST_FETCH;
               end
            end else begin
               // Stalled: hold the word until the downstream takes it.
               state_nx_s = ST_SEND;
            end
         end
         ST_DONE: begin
            busy_nx_s  = 1'b0;
            state_nx_s = ST_IDLE;
         end
         default: begin
            valid_nx_s = 1'b0;
            busy_nx_s  = 1'b0;
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by reset_n.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         addr_r     <= {ADDR_W{1'b0}};
         last_r     <= {ADDR_W{1'b0}};
         data_r     <= {DATA_W{1'b0}};
         index_r    <= {ADDR_W{1'b0}};
         checksum_r <= {DATA_W{1'b0}};
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         addr_r     <= addr_nx_s;
         last_r     <= last_nx_s;
         data_r     <= data_nx_s;
         index_r    <= index_nx_s;
         checksum_r <= checksum_nx_s;
         valid_r    <= valid_nx_s;
         busy_r     <= busy_nx_s;
         done_r     <= done_nx_s;
      end
   end

   assign read_reg  = addr_r;
   assign out_valid = valid_r;
   assign out_data  = data_r;
   assign out_index = index_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign checksum  = checksum_r;

endmodule

// File: tb/tb_register_dump.sv
// ----------------------------------------------------------------------------
// tb_register_dump
//
// Self-checking bench for register_dump. The bench holds a behavioural model
// of the 8x32 register file. Each dump's expected index sequence, word data,
// cycle timing and XOR checksum come from the range rules applied to that
// model. Directed scenarios are followed by randomized dumps with random
// register contents and random backpressure.
// ----------------------------------------------------------------------------
module tb_register_dump;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [2:0]  first_reg;
   logic [2:0]  last_reg;
   logic [2:0]  read_reg;
   logic [31:0] read_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_index;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   logic [31:0] regs [0:7];
   int          errors;
   int          checks;
   logic [31:0] last_cks;

   register_dump #(.ADDR_W(3), .DATA_W(32)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .first_reg (first_reg),
      .last_reg  (last_reg),
      .read_reg  (read_reg),
      .read_data (read_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   // Register file model: combinational read of read_reg.
   assign read_data = regs[read_reg];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Run one dump of first..last (wrapping mod 8). The model tracks the word
   // sequence, the cycle-exact handshake timing and the running checksum.
   task automatic run_dump(input int first, input int last, input int stall_first,
                           input bit rand_ready, input bit mid_start, input bit wr3);
      int          count;
      int          word;
      int          stalls;
      int          idx;
      bit          rdy;
      logic [31:0] exp_data;
      logic [31:0] model_cks;
      count       = ((last - first + 8) % 8) + 1;
      first_reg   = first[2:0];
      last_reg    = last[2:0];
      start       = 1'b1;
      out_ready   = 1'b0;
      cyc();
      start       = 1'b0;
      first_reg   = 3'($urandom);
      last_reg    = 3'($urandom);
      check_val("busy_rise",   32'(busy), 32'd1);
      check_val("fetch_valid", 32'(out_valid), 32'd0);
      check_val("cks_clear",   checksum, 32'd0);
      check_val("rreg_first",  32'(read_reg), 32'(first));
      model_cks = 32'd0;
      word      = 0;
      stalls    = 0;
      exp_data  = regs[first];
      cyc();
      while (word < count) begin
         idx = (first + word) % 8;
         check_val("send_valid", 32'(out_valid), 32'd1);
         check_val("send_index", 32'(out_index), 32'(idx));
         check_val("send_data",  out_data, exp_data);
         check_val("send_busy",  32'(busy), 32'd1);
         check_val("send_done",  32'(done), 32'd0);
         check_val("send_rreg",  32'(read_reg), 32'(idx));
         check_val("send_cks",   checksum, model_cks);
         if (wr3 && idx == 3)
            check_val("wr3_data", out_data, 32'hDEADBEEF);
         if (word == 0 && stalls < stall_first)
            rdy = 1'b0;
         else if (rand_ready && stalls < 4)
            rdy = ($urandom_range(0, 2) != 0);
         else
            rdy = 1'b1;
         out_ready = rdy;
         if (mid_start && word == 3 && stalls == 0) begin
            start     = 1'b1;
            first_reg = 3'($urandom);
            last_reg  = 3'($urandom);
         end
         // Write r3 on the edge that opens r3's FETCH cycle.
         if (rdy && wr3 && word + 1 < count && (idx + 1) % 8 == 3)
            regs[3] = 32'hDEADBEEF;
         cyc();
         start     = 1'b0;
         out_ready = 1'b0;
         if (!rdy) begin
            stalls++;
         end else begin
            model_cks ^= exp_data;
            word++;
            stalls = 0;
            if (word < count) begin
               check_val("fetch_valid2", 32'(out_valid), 32'd0);
               check_val("fetch_rreg",   32'(read_reg), 32'((first + word) % 8));
               exp_data = regs[(first + word) % 8];
               cyc();
            end
         end
      end
      check_val("done_pulse", 32'(done), 32'd1);
      check_val("done_busy",  32'(busy), 32'd1);
      check_val("done_valid", 32'(out_valid), 32'd0);
      check_val("done_cks",   checksum, model_cks);
      cyc();
      check_val("idle_done",  32'(done), 32'd0);
      check_val("idle_busy",  32'(busy), 32'd0);
      check_val("idle_valid", 32'(out_valid), 32'd0);
      check_val("idle_cks",   checksum, model_cks);
      last_cks = model_cks;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset_n   = 1'b0;
      start     = 1'b0;
      first_reg = 3'd0;
      last_reg  = 3'd0;
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) regs[k] = 32'd0;
      cyc();
      cyc();
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_busy",  32'(busy), 32'd0);
      check_val("rst_done",  32'(done), 32'd0);
      check_val("rst_rreg",  32'(read_reg), 32'd0);
      check_val("rst_data",  out_data, 32'd0);
      check_val("rst_index", 32'(out_index), 32'd0);
      check_val("rst_cks",   checksum, 32'd0);
      reset_n = 1'b1;
      cyc();

      // Single register
      regs[1] = 32'hFFFF1111;
      regs[2] = 32'hFFFF0000;
      run_dump(1, 1, 0, 1'b0, 1'b0, 1'b0);
      check_val("single_cks", last_cks, 32'hFFFF1111);
      check_val("single_rreg_idle", 32'(read_reg), 32'd1);

      // Range with backpressure
      run_dump(1, 2, 3, 1'b0, 1'b0, 1'b0);
      check_val("range_cks", last_cks, 32'h00001111);

      // Wrap-around
      for (int k = 0; k < 8; k++) regs[k] = 32'(k) + 32'h10;
      run_dump(6, 1, 0, 1'b0, 1'b0, 1'b0);
      check_val("wrap_cks", last_cks, 32'h00000000);

      // Full sweep with an ignored start mid-dump
      run_dump(0, 7, 0, 1'b0, 1'b1, 1'b0);
      check_val("sweep_cks", last_cks, 32'h00000000);

      // Reset mid-dump: reach SEND of the third word
      first_reg = 3'd0;
      last_reg  = 3'd7;
      start     = 1'b1;
      cyc();
      start     = 1'b0;
      cyc();
      out_ready = 1'b1;
      cyc();
      cyc();
      cyc();
      out_ready = 1'b0;
      cyc();
      check_val("pre_rst_valid", 32'(out_valid), 32'd1);
      check_val("pre_rst_index", 32'(out_index), 32'd2);
      reset_n = 1'b0;
      #2;
      check_val("mid_rst_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_busy",  32'(busy), 32'd0);
      check_val("mid_rst_cks",   checksum, 32'd0);
      check_val("mid_rst_rreg",  32'(read_reg), 32'd0);
      cyc();
      reset_n = 1'b1;
      cyc();
      check_val("post_rst_valid", 32'(out_valid), 32'd0);
      run_dump(2, 2, 0, 1'b0, 1'b0, 1'b0);
      check_val("post_rst_cks", last_cks, 32'h00000012);

      // Write during dump
      run_dump(0, 5, 0, 1'b0, 1'b0, 1'b1);
      check_val("wr3_cks", last_cks,
                32'h10 ^ 32'h11 ^ 32'h12 ^ 32'hDEADBEEF ^ 32'h14 ^ 32'h15);

      // Randomized dumps
      for (int n = 0; n < 25; n++) begin
         for (int k = 0; k < 8; k++) regs[k] = $urandom;
         run_dump(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
